// File: rtl/instruction_prefetch_buffer_pkg.sv
// Shared types and helpers for the instruction prefetch buffer.
package instruction_prefetch_buffer_pkg;

   localparam int unsigned WORD_W = 32;
   localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;

   typedef struct packed {
      logic [WORD_W-1:0] instr;
      logic [WORD_W-1:0] pc_plus_4;
   } prefetch_entry_t;

   typedef enum logic {
      PF_RUN,
      PF_END
   } pf_state_e;

   // True when all four bytes of the word at pc lie inside the memory.
   function automatic logic pc_in_range(input logic [WORD_W-1:0] pc, input int unsigned mem_bytes);
      return ({1'b0, pc} + 33'd3) < {1'b0, 32'(mem_bytes)};
   endfunction

endpackage

// File: rtl/instruction_prefetch_buffer_if.sv
// Redirect input and fetch-queue output handshake of the prefetch buffer.
interface instruction_prefetch_buffer_if;
   import instruction_prefetch_buffer_pkg::*;

   logic              redirect_valid;
   logic [WORD_W-1:0] redirect_target;
   logic              out_ready;
   logic              out_valid;
   logic [WORD_W-1:0] out_instruction;
   logic [WORD_W-1:0] out_pc_plus_4;
   logic              end_of_program;
   logic              misaligned_redirect;

   modport master (
      output redirect_valid, redirect_target, out_ready,
      input  out_valid, out_instruction, out_pc_plus_4, end_of_program, misaligned_redirect
   );

   modport slave (
      input  redirect_valid, redirect_target, out_ready,
      output out_valid, out_instruction, out_pc_plus_4, end_of_program, misaligned_redirect
   );
endinterface

// File: rtl/instruction_prefetch_buffer_fifo.sv
// DEPTH-entry synchronous FIFO whose head entry and valid flag are registered.
module instruction_prefetch_buffer_fifo
   import instruction_prefetch_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            push_i,
   input  logic            pop_i,
   input  logic            flush_i,
   input  prefetch_entry_t wdata_i,
   output prefetch_entry_t head_o,
   output logic            valid_o,
   output logic            full_c_o,
   output logic            empty_nxt_c_o
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   prefetch_entry_t mem_q [DEPTH];
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d, remain;
   prefetch_entry_t head_q, head_d;
   logic            valid_q, valid_d;

   // Head register tracks the entry that is at the front after this edge.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      head_d   = head_q;
      valid_d  = valid_q;
      remain   = count_q - CW'(pop_i);
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         valid_d  = 1'b0;
      end else begin
         if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
         if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
         count_d = remain + CW'(push_i);
         valid_d = (count_d != '0);
         if (remain != '0)  head_d = mem_q[rd_ptr_d];
         else if (push_i)   head_d = wdata_i;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '{instr: NOP_WORD, pc_plus_4: '0};
         valid_q  <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
         valid_q  <= valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign head_o        = head_q;
   assign valid_o       = valid_q;
   assign full_c_o      = (count_q == CW'(DEPTH));
   assign empty_nxt_c_o = (count_d == '0);
endmodule

// File: rtl/instruction_prefetch_buffer.sv
// Fetches big-endian words from instruction memory into a small queue,
// delivers them over valid/ready and restarts on a taken-branch redirect.
module instruction_prefetch_buffer
   import instruction_prefetch_buffer_pkg::*;
#(
   parameter int unsigned       DEPTH     = 4,
   parameter int unsigned       MEM_BYTES = 256,
   parameter logic [WORD_W-1:0] RESET_PC  = 32'h0000_0000
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [7:0]                    instruction_mem_i [MEM_BYTES],
   instruction_prefetch_buffer_if.slave  bus
);
   localparam int unsigned IW = $clog2(MEM_BYTES);

   logic [WORD_W-1:0] fetch_pc_q, fetch_pc_d;
   pf_state_e         state_q, state_d;
   logic              eop_q, eop_d;
   logic              mis_q, mis_d;

   logic              push_c, pop_c;
   logic              fifo_valid, fifo_full, fifo_empty_nxt;
   prefetch_entry_t   fifo_head, fetch_entry_c;
   logic [IW-1:0]     idx_c;
   logic [WORD_W-1:0] fetch_word_c;

   assign idx_c        = IW'(fetch_pc_q % 32'(MEM_BYTES));
   assign fetch_word_c = {instruction_mem_i[idx_c],
                          instruction_mem_i[idx_c + IW'(1)],
                          instruction_mem_i[idx_c + IW'(2)],
                          instruction_mem_i[idx_c + IW'(3)]};
   assign fetch_entry_c = '{instr: fetch_word_c, pc_plus_4: fetch_pc_q + 32'd4};

   // Redirect wins over push and pop; the pop it collides with is dropped.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      state_d    = state_q;
      push_c     = 1'b0;
      pop_c      = fifo_valid && bus.out_ready && !bus.redirect_valid;
      mis_d      = mis_q;
      if (bus.redirect_valid) begin
         fetch_pc_d = {bus.redirect_target[WORD_W-1:2], 2'b00};
         state_d    = PF_RUN;
         if (bus.redirect_target[1:0] != 2'b00) mis_d = 1'b1;
      end else if (state_q == PF_RUN) begin
         push_c = pc_in_range(fetch_pc_q, MEM_BYTES) && (!fifo_full || pop_c);
         if (push_c) fetch_pc_d = fetch_pc_q + 32'd4;
         state_d = pc_in_range(fetch_pc_d, MEM_BYTES) ? PF_RUN : PF_END;
      end
      eop_d = (state_d == PF_END) && fifo_empty_nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc_q <= RESET_PC;
         state_q    <= PF_RUN;
         eop_q      <= 1'b0;
         mis_q      <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         state_q    <= state_d;
         eop_q      <= eop_d;
         mis_q      <= mis_d;
      end
   end

   instruction_prefetch_buffer_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk           (clk),
      .reset         (reset),
      .push_i        (push_c),
      .pop_i         (pop_c),
      .flush_i       (bus.redirect_valid),
      .wdata_i       (fetch_entry_c),
      .head_o        (fifo_head),
      .valid_o       (fifo_valid),
      .full_c_o      (fifo_full),
      .empty_nxt_c_o (fifo_empty_nxt)
   );

   assign bus.out_valid           = fifo_valid;
   assign bus.out_instruction     = fifo_head.instr;
   assign bus.out_pc_plus_4       = fifo_head.pc_plus_4;
   assign bus.end_of_program      = eop_q;
   assign bus.misaligned_redirect = mis_q;
endmodule

// File: tb/tb_instruction_prefetch_buffer.sv
// Directed scoreboard bench for instruction_prefetch_buffer.
module tb_instruction_prefetch_buffer;
   import instruction_prefetch_buffer_pkg::*;

   localparam int unsigned MEM_BYTES = 256;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] mem [MEM_BYTES];
   int         total;
   int         bad;
   logic [31:0] last_pc4;
   prefetch_entry_t sb[$];

   instruction_prefetch_buffer_if bus ();

   instruction_prefetch_buffer #(
      .DEPTH     (4),
      .MEM_BYTES (MEM_BYTES),
      .RESET_PC  (32'h0000_0000)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .instruction_mem_i (mem),
      .bus               (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word_at(input int unsigned k);
      if (k == 0) return 32'h1234_5678;
      return 32'h1111_1111 * k;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected stream after a (re)start at t: every in-range word from t upward.
   task automatic refill(input logic [31:0] t);
      sb.delete();
      for (int unsigned a = {t[31:2], 2'b00}; a + 3 < MEM_BYTES; a += 4)
         sb.push_back('{instr: word_at(a / 4), pc_plus_4: a + 4});
   endtask

   task automatic cycle(input logic rdy, input logic redir, input logic [31:0] tgt);
      bus.out_ready       = rdy;
      bus.redirect_valid  = redir;
      bus.redirect_target = tgt;
      if (redir) begin
         refill(tgt);
      end else if (bus.out_valid && rdy) begin
         total++;
         assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL sb_extra observed=%h expected=none", bus.out_instruction);
         end
         if (sb.size() != 0) begin
            chk("sb_instr", bus.out_instruction, sb[0].instr);
            chk("sb_pc4", bus.out_pc_plus_4, sb[0].pc_plus_4);
            last_pc4 = sb[0].pc_plus_4;
            void'(sb.pop_front());
         end
      end
      @(posedge clk);
      #1;
      bus.redirect_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [31:0] w;
      total    = 0;
      bad      = 0;
      last_pc4 = '0;
      for (int k = 0; k < MEM_BYTES / 4; k++) begin
         w = word_at(k);
         mem[4*k]     = w[31:24];
         mem[4*k + 1] = w[23:16];
         mem[4*k + 2] = w[15:8];
         mem[4*k + 3] = w[7:0];
      end
      reset               = 1'b0;
      bus.out_ready       = 1'b0;
      bus.redirect_valid  = 1'b0;
      bus.redirect_target = '0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(bus.out_valid), 0);
      chk("rst_instr", bus.out_instruction, 0);
      chk("rst_pc4", bus.out_pc_plus_4, 0);
      chk("rst_eop", 32'(bus.end_of_program), 0);
      chk("rst_mis", 32'(bus.misaligned_redirect), 0);
      #3 reset = 1'b1;
      refill(32'h0);

      // Stall from the start: queue fills and fetch freezes.
      cycle(1'b0, 1'b0, '0);
      chk("first_valid", 32'(bus.out_valid), 1);
      chk("be_word0", bus.out_instruction, 32'h1234_5678);
      chk("first_pc4", bus.out_pc_plus_4, 32'd4);
      repeat (9) cycle(1'b0, 1'b0, '0);
      chk("stall_count", 32'(dut.u_fifo.count_q), 4);
      chk("stall_pc", dut.fetch_pc_q, 32'd16);
      cycle(1'b0, 1'b0, '0);
      chk("stall_pc_frozen", dut.fetch_pc_q, 32'd16);

      // Release: one word per cycle with the queue staying full.
      for (int i = 0; i < 12; i++) begin
         cycle(1'b1, 1'b0, '0);
         chk("thru_valid", 32'(bus.out_valid), 1);
      end
      chk("full_count", 32'(dut.u_fifo.count_q), 4);

      // Redirect while full and draining.
      cycle(1'b1, 1'b1, 32'h40);
      chk("redir_gap", 32'(bus.out_valid), 0);
      cycle(1'b1, 1'b0, '0);
      chk("redir_valid", 32'(bus.out_valid), 1);
      chk("redir_instr", bus.out_instruction, word_at(16));
      chk("redir_pc4", bus.out_pc_plus_4, 32'h44);
      chk("mis_clear", 32'(bus.misaligned_redirect), 0);
      repeat (3) cycle(1'b1, 1'b0, '0);

      // Misaligned redirect, then sticky across an aligned one.
      cycle(1'b1, 1'b1, 32'h42);
      chk("mis_set", 32'(bus.misaligned_redirect), 1);
      cycle(1'b1, 1'b0, '0);
      chk("mis_instr", bus.out_instruction, word_at(16));
      chk("mis_pc4", bus.out_pc_plus_4, 32'h44);
      cycle(1'b1, 1'b1, 32'h80);
      cycle(1'b1, 1'b0, '0);
      chk("mis_sticky", 32'(bus.misaligned_redirect), 1);

      // Run off the end of memory with occasional stalls.
      n = 0;
      while (!bus.end_of_program && n < 300) begin
         cycle(n % 5 != 3, 1'b0, '0);
         n++;
      end
      chk("eop", 32'(bus.end_of_program), 1);
      chk("last_pc4", last_pc4, 32'h100);
      chk("sb_drained", 32'(sb.size()), 0);
      chk("state_end", 32'(dut.state_q), 32'(PF_END));
      chk("eop_valid", 32'(bus.out_valid), 0);

      cycle(1'b1, 1'b1, 32'h0);
      chk("eop_clear", 32'(bus.end_of_program), 0);
      chk("state_run", 32'(dut.state_q), 32'(PF_RUN));
      cycle(1'b1, 1'b0, '0);
      chk("resume_instr", bus.out_instruction, 32'h1234_5678);

      // Redirect straight past the end of memory.
      cycle(1'b1, 1'b1, 32'h100);
      cycle(1'b1, 1'b0, '0);
      chk("oor_eop", 32'(bus.end_of_program), 1);
      chk("oor_valid", 32'(bus.out_valid), 0);

      // Asynchronous reset between edges with a full queue.
      cycle(1'b1, 1'b1, 32'h0);
      repeat (6) cycle(1'b0, 1'b0, '0);
      chk("pre_reset_count", 32'(dut.u_fifo.count_q), 4);
      #3 reset = 1'b0;
      #1;
      chk("async_valid", 32'(bus.out_valid), 0);
      chk("async_count", 32'(dut.u_fifo.count_q), 0);
      chk("async_mis", 32'(bus.misaligned_redirect), 0);
      #2 reset = 1'b1;
      refill(32'h0);
      cycle(1'b1, 1'b0, '0);
      chk("post_reset_valid", 32'(bus.out_valid), 1);
      chk("post_reset_instr", bus.out_instruction, 32'h1234_5678);
      repeat (8) cycle(1'b1, 1'b0, '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
